// File: rtl/cla_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_serial_adder
//   Multi-cycle carry-lookahead adder. Two WIDTH-bit operands are summed
//   CHUNK bits per clock. Each chunk uses per-bit terms p=a|b, g=a&b and
//   s=a^b^c. A flattened CHUNK-wide lookahead unit produces the carries.
//   A carry register links successive chunks. A second lookahead evaluation,
//   seeded with 0, runs alongside and yields the group generate term.
//
//   Handshake: start is sampled only in IDLE. When it is accepted, a, b and
//   cin are captured. busy is high while chunks are processed. done pulses
//   for one cycle when sum/cout/ovf/gp/gg are valid. The outputs hold their
//   values until the RUN phase of the next accepted add.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      add request (sampled in IDLE only)
//   a, b       in   WIDTH  operands, captured with start
//   cin        in   1      carry-in, captured with start
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle result-valid pulse
//   sum        out  WIDTH  result (mod 2^WIDTH)
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow (carry into MSB ^ carry out)
//   gp         out  1      AND of all p[i]
//   gg         out  1      carry-out with cin forced to 0
//   state_dbg  out  2      current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module cla_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             gp,
  output logic             gg,
  output logic [1:0]       state_dbg
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Flattened lookahead: each carry is a sum of products. Every product
  // is a generate bit ANDed with the propagates above it, or the chunk
  // carry-in ANDed with all propagates below the carry. No carry depends
  // on another computed carry.
  function automatic logic [CHUNK:0] cla_carries(
    input logic [CHUNK-1:0] p,
    input logic [CHUNK-1:0] g,
    input logic             c0
  );
    logic [CHUNK:0] c;
    logic           cv;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int j = 0; j < CHUNK; j++) begin
      cv = g[j];
      for (int i = 0; i < j; i++) begin
        term = g[i];
        for (int k = i + 1; k <= j; k++) term = term & p[k];
        cv = cv | term;
      end
      term = c0;
      for (int k = 0; k <= j; k++) term = term & p[k];
      c[j+1] = cv | term;
    end
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 carry_q, carry_d;
  logic                 gg_carry_q, gg_carry_d;
  logic                 gp_acc_q, gp_acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 gp_q, gp_d;
  logic                 gg_q, gg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // The operand registers shift right by CHUNK on every RUN edge, so the
  // active chunk is always in the low bits. The sum fills from the top.
  // After N edges, chunk 0 reaches the bottom of sum.
  logic [CHUNK-1:0]     p_c, g_c, s_c;
  logic [CHUNK:0]       c_c, cg_c;
  logic                 last_c;

  always_comb begin
    p_c    = a_q[CHUNK-1:0] | b_q[CHUNK-1:0];
    g_c    = a_q[CHUNK-1:0] & b_q[CHUNK-1:0];
    c_c    = cla_carries(p_c, g_c, carry_q);
    cg_c   = cla_carries(p_c, g_c, gg_carry_q);
    s_c    = a_q[CHUNK-1:0] ^ b_q[CHUNK-1:0] ^ c_c[CHUNK-1:0];
    last_c = (idx_q == IDX_W'(N - 1));

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    gg_carry_d = gg_carry_q;
    gp_acc_d   = gp_acc_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    gp_d       = gp_q;
    gg_d       = gg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          gg_carry_d = 1'b0;
          gp_acc_d   = 1'b1;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        a_d        = a_q >> CHUNK;
        b_d        = b_q >> CHUNK;
        sum_d      = (sum_q >> CHUNK) | (WIDTH'(s_c) << (WIDTH - CHUNK));
        carry_d    = c_c[CHUNK];
        gg_carry_d = cg_c[CHUNK];
        gp_acc_d   = gp_acc_q & (&p_c);
        idx_d      = idx_q + IDX_W'(1);
        if (last_c) begin
          cout_d  = c_c[CHUNK];
          ovf_d   = c_c[CHUNK-1] ^ c_c[CHUNK];
          gp_d    = gp_acc_q & (&p_c);
          gg_d    = cg_c[CHUNK];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately ignored here.
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      gg_carry_q <= 1'b0;
      gp_acc_q   <= 1'b0;
      idx_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      gp_q       <= 1'b0;
      gg_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      gg_carry_q <= gg_carry_d;
      gp_acc_q   <= gp_acc_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      gp_q       <= gp_d;
      gg_q       <= gg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign gp        = gp_q;
  assign gg        = gg_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_adder
//   Self-checking bench for cla_serial_adder (WIDTH=16, CHUNK=4).
//   Expected results come from plain integer arithmetic on the operands.
//   They are pushed into exp_q when start is driven and popped when done
//   arrives.
//   Handshake: start is held for one cycle, from a negedge to the next
//   negedge. The DUT accepts it on the rising edge in between, if it is
//   IDLE. Outputs are sampled on negedges.
// ---------------------------------------------------------------------------
module tb_cla_serial_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
  localparam int RW    = WIDTH + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, busy, done, cout, ovf, gp, gg;
  logic [1:0]       state_dbg;

  cla_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .gp(gp), .gg(gg), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {sum, cout, ovf, gp, gg} from ordinary integer addition.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic ci);
    logic [WIDTH:0] full, full_nc;
    logic           ov;
    full    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    full_nc = {1'b0, x} + {1'b0, y};
    ov      = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {full[WIDTH-1:0], full[WIDTH], ov, &(x | y), full_nc[WIDTH]};
  endfunction

  // driver: one complete add. If inject is set, start is pulsed once in
  // RUN with other operands, and again in the DONE cycle. Both pulses must
  // be ignored.
  task automatic run_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input bit inject);
    int            cycles;
    logic [RW-1:0] exp;
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = ci;
    exp_q.push_back(model(x, y, ci));
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check("busy_in_run", 32'(busy), 32'd1);
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      start = inject && (cycles == 2);
      if (start) begin
        a = 16'h1234; b = 16'h4321; cin = ~ci;
      end
    end
    check("latency", 32'(cycles), 32'(N + 1));
    if (exp_q.size() == 0) begin
      exp = '0;
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
    end
    check("sum", 32'(sum), 32'(exp[RW-1:4]));
    check("cout_ovf_gp_gg", 32'({cout, ovf, gp, gg}), 32'(exp[3:0]));
    check("busy_in_done", 32'(busy), 32'd0);
    if (inject) begin
      start = 1'b1; a = 16'h5555; b = 16'h5555;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", 32'({sum, cout, ovf, gp, gg}), 32'(exp));
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_flags"}, 32'({cout, ovf, gp, gg}), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  logic [WIDTH-1:0] rx, ry;
  logic             rc;
  int               seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // directed cases
    run_add(16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_add(16'h8000, 16'h8000, 1'b0, 1'b0);
    run_add(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);

    // reset in the middle of RUN: rst is sampled at the second RUN edge
    @(negedge clk);
    start = 1'b1; a = 16'h0FFF; b = 16'h0FFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_run_reset");
    seen_done = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("no_done_after_reset", 32'(seen_done), 32'd0);
    run_add(16'h0FFF, 16'h0FFF, 1'b1, 1'b0);

    // randomized, with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       rx = 16'hFFFF;
        1:       rx = 16'h7FFF;
        2:       rx = 16'h8000;
        default: rx = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       ry = 16'h0000;
        1:       ry = 16'h0001;
        2:       ry = 16'hFFFF;
        default: ry = WIDTH'($urandom);
      endcase
      rc = 1'($urandom_range(0, 1));
      run_add(rx, ry, rc, ($urandom_range(0, 3) == 0));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
